// File: rtl/cool_heat_pkg.sv
// Shared types and constants for the thermostat controller: mode encoding
// and the cooling fan speed-level table.
package cool_heat_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_COOL  = 2'd1,
        MODE_HEAT  = 2'd2,
        MODE_DRAIN = 2'd3
    } mode_e;

    localparam logic [7:0] COOL_T1 = 8'd40;
    localparam logic [7:0] COOL_T2 = 8'd45;
    localparam logic [7:0] COOL_T3 = 8'd50;

    localparam logic [7:0] COOL_DUTY0 = 8'd64;
    localparam logic [7:0] COOL_DUTY1 = 8'd128;
    localparam logic [7:0] COOL_DUTY2 = 8'd192;
    localparam logic [7:0] COOL_DUTY3 = 8'd255;

    // Hotter readings demand more airflow while cooling.
    function automatic logic [7:0] cool_duty(input logic [7:0] t);
        if (t < COOL_T1)      return COOL_DUTY0;
        else if (t < COOL_T2) return COOL_DUTY1;
        else if (t < COOL_T3) return COOL_DUTY2;
        else                  return COOL_DUTY3;
    endfunction

endpackage

// File: rtl/fan_ramp.sv
// Rate limiter for the fan duty: moves fan_speed toward target by at most
// RAMP_STEP once every RAMP_DIV clocks, and flags when the two agree.
module fan_ramp #(
    parameter int         RAMP_DIV  = 16,
    parameter logic [7:0] RAMP_STEP = 8'd4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] target,
    output logic [7:0] fan_speed,
    output logic       at_target
);

    localparam int            CW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [7:0]    gap;
    logic [7:0]    step;
    logic [8:0]    speed_wide;
    logic [7:0]    speed_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick       = (cnt == CNT_MAX);
        gap        = (fan_speed < target) ? (target - fan_speed) : (fan_speed - target);
        step       = (gap < RAMP_STEP) ? gap : RAMP_STEP;
        speed_wide = {1'b0, fan_speed};
        if (tick) begin
            if (fan_speed < target)
                speed_wide = {1'b0, fan_speed} + {1'b0, step};
            else if (fan_speed > target)
                speed_wide = {1'b0, fan_speed} - {1'b0, step};
        end
        // step never exceeds the gap, so bit 8 stays clear; saturate defensively.
        speed_next = speed_wide[8] ? 8'hFF : speed_wide[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt       <= '0;
            fan_speed <= 8'd0;
            at_target <= 1'b1;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            fan_speed <= speed_next;
            at_target <= (speed_next == target);
        end
    end

endmodule

// File: rtl/cool_heat_ctrl.sv
// Thermostat controller: hysteresis mode FSM driving cooler/heater enables
// and a rate-limited fan duty target.
module cool_heat_ctrl
    import cool_heat_pkg::*;
#(
    parameter logic [7:0] COOL_ON    = 8'd35,
    parameter logic [7:0] COOL_OFF   = 8'd25,
    parameter logic [7:0] HEAT_ON    = 8'd15,
    parameter logic [7:0] HEAT_OFF   = 8'd20,
    parameter logic [7:0] HEAT_SPEED = 8'd128,
    parameter int         RAMP_DIV   = 16,
    parameter logic [7:0] RAMP_STEP  = 8'd4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    output logic [7:0] fan_speed,
    output logic       cooler_on,
    output logic       heater_on,
    output logic [1:0] mode,
    output logic       at_target
);

    mode_e      state;
    mode_e      state_next;
    logic [7:0] t_q;
    logic [7:0] target;
    logic       cooler_next;
    logic       heater_next;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= MODE_IDLE;
            t_q       <= 8'd0;
            cooler_on <= 1'b0;
            heater_on <= 1'b0;
        end else begin
            state     <= state_next;
            cooler_on <= cooler_next;
            heater_on <= heater_next;
            if (temp_valid)
                t_q <= temp;
        end
    end

    // Decisions use the incoming temp directly, so a strobe acts on the very next edge.
    always_comb begin
        state_next = state;
        unique case (state)
            MODE_IDLE: begin
                if (enable && temp_valid) begin
                    if (temp >= COOL_ON)      state_next = MODE_COOL;
                    else if (temp <= HEAT_ON) state_next = MODE_HEAT;
                end
            end
            MODE_COOL: begin
                if (!enable || (temp_valid && temp <= COOL_OFF))
                    state_next = MODE_DRAIN;
            end
            MODE_HEAT: begin
                if (!enable || (temp_valid && temp >= HEAT_OFF))
                    state_next = MODE_DRAIN;
            end
            MODE_DRAIN: begin
                if (fan_speed == 8'd0)
                    state_next = MODE_IDLE;
            end
            default: state_next = MODE_IDLE;
        endcase
    end

    always_comb begin
        cooler_next = (state_next == MODE_COOL);
        heater_next = (state_next == MODE_HEAT);
        unique case (state)
            MODE_COOL: target = cool_duty(t_q);
            MODE_HEAT: target = HEAT_SPEED;
            default:   target = 8'd0;
        endcase
    end

    assign mode = state;

    fan_ramp #(
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP)
    ) u_fan_ramp (
        .clk       (clk),
        .arst      (arst),
        .target    (target),
        .fan_speed (fan_speed),
        .at_target (at_target)
    );

endmodule

// File: tb/tb_cool_heat_ctrl.sv
// Directed bench for cool_heat_ctrl: mode sequencing, hysteresis, ramp
// timing, ramp floor, asynchronous reset and enable drop.
module tb_cool_heat_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] temp = 8'd22;
    logic       temp_valid = 1'b0;
    logic [7:0] fan_speed;
    logic       cooler_on;
    logic       heater_on;
    logic [1:0] mode;
    logic       at_target;

    int vectors = 0;
    int miscompares = 0;

    cool_heat_ctrl dut (
        .clk        (clk),
        .arst       (arst),
        .enable     (enable),
        .temp       (temp),
        .temp_valid (temp_valid),
        .fan_speed  (fan_speed),
        .cooler_on  (cooler_on),
        .heater_on  (heater_on),
        .mode       (mode),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // Callers sit on a negedge; the strobe spans exactly one rising edge.
    task automatic strobe(input logic [7:0] t);
        temp       = t;
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fan(input logic [7:0] v, input int budget, input string name);
        int n = 0;
        while (fan_speed !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (fan_speed !== v) begin
            miscompares++;
            $display("FAIL %s: fan_speed=%0d required %0d within %0d clks", name, fan_speed, v, budget);
        end
    endtask

    task automatic wait_mode(input logic [1:0] v, input int budget, input string name);
        int n = 0;
        while (mode !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (mode !== v) begin
            miscompares++;
            $display("FAIL %s: mode=%0d required %0d within %0d clks", name, mode, v, budget);
        end
    endtask

    task automatic test_reset();
        clocks(3);
        vectors++;
        if ({mode, fan_speed, cooler_on, heater_on, at_target} !== {2'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: mode=%0d fan=%0d cool=%b heat=%b at=%b required 0 0 0 0 1",
                     mode, fan_speed, cooler_on, heater_on, at_target);
        end
        arst = 1'b0;
        clocks(2);
        for (int i = 0; i < 3; i++) begin
            strobe(8'd22);
            clocks(2);
        end
        vectors++;
        if ({mode, fan_speed, cooler_on, heater_on} !== {2'd0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_idle_22: mode=%0d fan=%0d cool=%b heat=%b required 0 0 0 0",
                     mode, fan_speed, cooler_on, heater_on);
        end
    endtask

    task automatic test_cool_ramp();
        strobe(8'd36);
        vectors++;
        if ({mode, cooler_on, heater_on} !== {2'd1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL cool_entry: mode=%0d cool=%b heat=%b required 1 1 0", mode, cooler_on, heater_on);
        end
        clocks(128);
        vectors++;
        if ({fan_speed, at_target} !== {8'd32, 1'b0}) begin
            miscompares++;
            $display("FAIL cool_ramp_half: fan=%0d at=%b required 32 0", fan_speed, at_target);
        end
        clocks(128);
        vectors++;
        if ({fan_speed, at_target} !== {8'd64, 1'b1}) begin
            miscompares++;
            $display("FAIL cool_ramp_64: fan=%0d at=%b required 64 1", fan_speed, at_target);
        end
        clocks(32);
        vectors++;
        if (fan_speed !== 8'd64) begin
            miscompares++;
            $display("FAIL cool_hold_64: fan=%0d required 64", fan_speed);
        end
    endtask

    task automatic test_speed_levels();
        strobe(8'd47);
        clocks(256);
        vectors++;
        if ({fan_speed, at_target, mode} !== {8'd128, 1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL level_192_mid: fan=%0d at=%b mode=%0d required 128 0 1", fan_speed, at_target, mode);
        end
        clocks(256);
        vectors++;
        if ({fan_speed, at_target} !== {8'd192, 1'b1}) begin
            miscompares++;
            $display("FAIL level_192: fan=%0d at=%b required 192 1", fan_speed, at_target);
        end
        strobe(8'd25);
        vectors++;
        if ({mode, cooler_on} !== {2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL cool_off_25: mode=%0d cool=%b required 3 0", mode, cooler_on);
        end
        clocks(384);
        vectors++;
        if ({fan_speed, mode} !== {8'd96, 2'd3}) begin
            miscompares++;
            $display("FAIL drain_mid: fan=%0d mode=%0d required 96 3", fan_speed, mode);
        end
        clocks(384);
        vectors++;
        if (fan_speed !== 8'd0) begin
            miscompares++;
            $display("FAIL drain_zero: fan=%0d required 0", fan_speed);
        end
        clocks(2);
        vectors++;
        if (mode !== 2'd0) begin
            miscompares++;
            $display("FAIL drain_to_idle: mode=%0d required 0", mode);
        end
    endtask

    task automatic test_heat();
        strobe(8'd14);
        vectors++;
        if ({mode, heater_on, cooler_on} !== {2'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL heat_entry: mode=%0d heat=%b cool=%b required 2 1 0", mode, heater_on, cooler_on);
        end
        clocks(512);
        vectors++;
        if ({fan_speed, at_target} !== {8'd128, 1'b1}) begin
            miscompares++;
            $display("FAIL heat_ramp: fan=%0d at=%b required 128 1", fan_speed, at_target);
        end
        strobe(8'd40);
        vectors++;
        if ({mode, heater_on, cooler_on} !== {2'd3, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL heat_to_drain: mode=%0d heat=%b cool=%b required 3 0 0", mode, heater_on, cooler_on);
        end
        clocks(4);
        strobe(8'd40);
        vectors++;
        if ({mode, cooler_on} !== {2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_ignores_strobe: mode=%0d cool=%b required 3 0", mode, cooler_on);
        end
        wait_mode(2'd0, 700, "heat_drain_idle");
        strobe(8'd40);
        vectors++;
        if ({mode, cooler_on} !== {2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL idle_to_cool_40: mode=%0d cool=%b required 1 1", mode, cooler_on);
        end
    endtask

    task automatic test_hysteresis_and_floor();
        logic [7:0] prev;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_next;
        int         n;
        strobe(8'd30);
        clocks(3);
        vectors++;
        if ({mode, cooler_on} !== {2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL cool_hyst_30: mode=%0d cool=%b required 1 1", mode, cooler_on);
        end
        strobe(8'd55);
        wait_fan(8'd255, 1200, "cool_ramp_255");
        clocks(2);
        vectors++;
        if (at_target !== 1'b1) begin
            miscompares++;
            $display("FAIL at_target_255: at=%b required 1", at_target);
        end
        strobe(8'd20);
        prev = fan_speed;
        b1   = 8'd0;
        b2   = 8'd0;
        n    = 0;
        while (fan_speed != 8'd0 && n < 1200) begin
            @(negedge clk);
            n++;
            if (fan_speed != prev) begin
                exp_next = (prev >= 8'd4) ? prev - 8'd4 : 8'd0;
                vectors++;
                if (fan_speed !== exp_next) begin
                    miscompares++;
                    $display("FAIL floor_step: fan=%0d after %0d required %0d", fan_speed, prev, exp_next);
                end
                b2   = b1;
                b1   = prev;
                prev = fan_speed;
            end
        end
        vectors++;
        if ({fan_speed, b1, b2} !== {8'd0, 8'd3, 8'd7}) begin
            miscompares++;
            $display("FAIL floor_tail: last=%0d,%0d,%0d required 7,3,0", b2, b1, fan_speed);
        end
        wait_mode(2'd0, 20, "floor_idle");
        strobe(8'd30);
        clocks(20);
        vectors++;
        if ({mode, fan_speed, cooler_on, heater_on} !== {2'd0, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_hyst_30: mode=%0d fan=%0d cool=%b heat=%b required 0 0 0 0",
                     mode, fan_speed, cooler_on, heater_on);
        end
    endtask

    task automatic test_async_reset();
        strobe(8'd14);
        wait_fan(8'd128, 700, "heat_before_reset");
        strobe(8'd25);
        vectors++;
        if (mode !== 2'd3) begin
            miscompares++;
            $display("FAIL heat_off_25: mode=%0d required 3", mode);
        end
        wait_fan(8'd100, 200, "drain_at_100");
        #2;
        arst = 1'b1;
        #1;
        vectors++;
        if ({mode, fan_speed, cooler_on, heater_on, at_target} !== {2'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: mode=%0d fan=%0d cool=%b heat=%b at=%b required 0 0 0 0 1",
                     mode, fan_speed, cooler_on, heater_on, at_target);
        end
        @(negedge clk);
        arst = 1'b0;
        clocks(40);
        vectors++;
        if ({mode, fan_speed} !== {2'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL after_reset: mode=%0d fan=%0d required 0 0", mode, fan_speed);
        end
    endtask

    task automatic test_enable_drop();
        strobe(8'd14);
        clocks(3);
        vectors++;
        if ({mode, heater_on} !== {2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL heat_again: mode=%0d heat=%b required 2 1", mode, heater_on);
        end
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mode, heater_on} !== {2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL enable_drop: mode=%0d heat=%b required 3 0", mode, heater_on);
        end
        wait_mode(2'd0, 100, "enable_drop_idle");
        strobe(8'd10);
        clocks(2);
        strobe(8'd50);
        clocks(2);
        vectors++;
        if ({mode, heater_on, cooler_on} !== {2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL disabled_hold: mode=%0d heat=%b cool=%b required 0 0 0", mode, heater_on, cooler_on);
        end
        enable = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_cool_ramp();
        test_speed_levels();
        test_heat();
        test_hysteresis_and_floor();
        test_async_reset();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
